ps2_mouse_packet_rx: RTL
========================

// Module: ps2_mouse_packet_rx
// PURPOSE
//  Parametrised PS/2 mouse packet receiver; successor to the fixed 33-bit mouse decoder.
//  Frames device-to-host bytes on ps2_clk with a per-byte FSM and checks start, parity and
//  stop bits. Assembles 3-byte (standard) or 4-byte (wheel) packets and publishes decoded
//  movement, buttons and paddle speed/dir. Publication uses a toggle handshake so the
//  25 MHz game logic can synchronise it.
// PARAMETERS
//  BYTES_PER_PKT  3  bytes per packet: 3 = standard, 4 = wheel; other values illegal
//  SPEED_W        8  paddle_speed width, 1..9
//  AXIS_Y         1  1: paddle from Y movement; 0: from X movement
//  ERR_CNT_W      8  width of saturating error counter
// PORTS
//  ps2_clk       in   1          PS/2 clock from device; all registers use its falling edge
//  reset         in   1          asynchronous, active-high
//  ps2_data      in   1          PS/2 data line, sampled on ps2_clk falling edge
//  dx            out  9          signed X movement {byte0[4], byte1}
//  dy            out  9          signed Y movement {byte0[5], byte2}
//  x_ovf         out  1          byte0[6]
//  y_ovf         out  1          byte0[7]
//  buttons       out  3          byte0[2:0]: {middle, right, left}
//  wheel         out  4          signed byte3[3:0] when BYTES_PER_PKT==4, else 0
//  paddle_dir    out  1          sign bit of selected axis
//  paddle_speed  out  SPEED_W    saturated magnitude of selected axis
//  pkt_toggle    out  1          inverts once per accepted packet
//  error_flag    out  1          1 = last terminated packet was rejected
//  err_count     out  ERR_CNT_W  rejected-packet count, saturating
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; byte index = 0; shift register cleared.
//  Per-byte FSM (one ps2_clk falling edge per state step):
//   IDLE: ps2_data==0 -> DATA with bit_cnt=0; ps2_data==1 -> stay (bus idle/noise).
//   DATA: shift ps2_data in LSB first; after 8th bit -> PARITY.
//   PARITY: store bit; odd parity is required over data + parity -> STOP.
//   STOP: ps2_data must be 1. Byte good -> store at byte index and go IDLE.
//  Byte-level checks, evaluated at STOP:
//   - stop bit 0, parity error (see CONFIGURATION), or byte index 0 with data[3]==0 (sync).
//   - Any failure: discard partial packet, byte index <- 0, error_flag <- 1,
//     err_count += 1 (holds at all-ones), pkt_toggle unchanged, decoded outputs hold.
//  Packet accept: at STOP of byte index BYTES_PER_PKT-1 with no error, on that edge:
//   - dx, dy, ovf, buttons, wheel and paddle_* all update together.
//   - pkt_toggle inverts; error_flag <- 0; byte index <- 0.
//   - Latency: outputs valid at the same edge that samples the final stop bit.
//  Paddle: d = selected axis (dy if AXIS_Y else dx); paddle_dir = d[8].
//   mag = |d| (-256 -> 256); paddle_speed = (ovf of axis) ? all-ones
//   : min(mag, 2^SPEED_W-1).
//  Outputs hold between packets; consumer detects new data by 2-flop syncing pkt_toggle and
//   edge-detecting it. Data is stable for >=33 ps2_clk periods after each toggle.
//  Wrap: byte index wraps to 0 after last byte; err_count never wraps.
//  Reset mid-byte or mid-packet: partial data lost; first packet after reset must begin at
//   a fresh start bit. No toggle is generated by reset.
// CONFIGURATION
//  PS2_RX_PARITY_EN defined: parity failure rejects the packet as above.
//  Not defined: parity bit sampled and ignored; only stop and sync checks reject.
// TESTING
//  1 std pkt 0x28,0x05,0xFB (Y neg), AXIS_Y=1 -> dy=-5, dx=+5, paddle_dir=1,
//    paddle_speed=5, toggle flips once, error_flag=0.
//  2 byte0=0x88 (Y ovf) -> paddle_speed=0xFF regardless of byte2;
//    dy=0x020,SPEED_W=4 -> paddle_speed=0xF.
//  3 stop bit 0 on byte1 -> error_flag=1, err_count=1, toggle unchanged; next good pkt
//    accepted, error_flag=0.
//  4 bad parity on byte2 -> with PS2_RX_PARITY_EN rejected (err_count+1);
//    without it accepted.
//  5 BYTES_PER_PKT=4, bytes 0x08,0x00,0x00,0x0F -> wheel=-1, toggle flips only after
//    4th byte; byte0=0x00 -> sync error.
//  6 reset asserted after 2 bytes, then full pkt -> outputs 0 until pkt end,
//    single toggle, err_count=0.

Source files
------------

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse packet receiver: frames device-to-host bytes, assembles 3- or 4-byte packets and
// publishes decoded movement through a toggle handshake. Define PS2_RX_PARITY_EN to reject on parity.
`timescale 1ns/1ps
module ps2_mouse_packet_rx #(
    parameter int BYTES_PER_PKT = 3,
    parameter int SPEED_W       = 8,
    parameter int AXIS_Y        = 1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 ps2_clk,
    input  logic                 reset,
    input  logic                 ps2_data,
    output logic [8:0]           dx,
    output logic [8:0]           dy,
    output logic                 x_ovf,
    output logic                 y_ovf,
    output logic [2:0]           buttons,
    output logic [3:0]           wheel,
    output logic                 paddle_dir,
    output logic [SPEED_W-1:0]   paddle_speed,
    output logic                 pkt_toggle,
    output logic                 error_flag,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Bytes before the last one are buffered; the last byte is still in the shift register at accept.
    localparam int            NSTORE    = BYTES_PER_PKT - 1;
    localparam logic [1:0]    LAST_IDX  = 2'(BYTES_PER_PKT - 1);
    localparam logic [8:0]    SPEED_MAX = 9'((1 << SPEED_W) - 1);

    if ((BYTES_PER_PKT != 3) && (BYTES_PER_PKT != 4)) begin : g_bad_bytes
        $error("BYTES_PER_PKT must be 3 or 4");
    end
    if ((SPEED_W < 1) || (SPEED_W > 9)) begin : g_bad_speed_w
        $error("SPEED_W must be in 1..9");
    end

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [7:0]             pkt_q [NSTORE];
    logic [7:0]             pkt_d [NSTORE];

    logic [8:0]             dx_q, dx_d;
    logic [8:0]             dy_q, dy_d;
    logic                   x_ovf_q, x_ovf_d;
    logic                   y_ovf_q, y_ovf_d;
    logic [2:0]             buttons_q, buttons_d;
    logic [3:0]             wheel_q, wheel_d;
    logic                   dir_q, dir_d;
    logic [SPEED_W-1:0]     speed_q, speed_d;
    logic                   toggle_q, toggle_d;
    logic                   err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Decoded view of the packet as it would be published on this edge.
    logic [7:0]             byte0_c, byte1_c, byte2_c;
    logic [3:0]             wheel_c;
    logic [8:0]             dx_c, dy_c, axis_c, mag_c;
    logic                   axis_ovf_c;
    logic [SPEED_W-1:0]     speed_c;

    logic                   stop_ok, parity_ok, sync_ok, byte_good, last_byte;

    assign byte0_c = pkt_q[0];
    assign byte1_c = pkt_q[1];

    if (BYTES_PER_PKT == 4) begin : g_wheel
        assign byte2_c = pkt_q[NSTORE-1];
        assign wheel_c = shift_q[3:0];
    end else begin : g_std
        assign byte2_c = shift_q;
        assign wheel_c = 4'h0;
    end

    assign dx_c       = {byte0_c[4], byte1_c};
    assign dy_c       = {byte0_c[5], byte2_c};
    assign axis_c     = (AXIS_Y != 0) ? dy_c : dx_c;
    assign axis_ovf_c = (AXIS_Y != 0) ? byte0_c[7] : byte0_c[6];
    // Unsigned 9-bit magnitude: -256 maps to 9'h100 without overflow.
    assign mag_c      = axis_c[8] ? (~axis_c + 9'd1) : axis_c;
    assign speed_c    = (axis_ovf_c || (mag_c > SPEED_MAX)) ? '1 : mag_c[SPEED_W-1:0];

    assign stop_ok   = ps2_data;
`ifdef PS2_RX_PARITY_EN
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif
    assign sync_ok   = (byte_idx_q != 2'd0) || shift_q[3];
    assign byte_good = stop_ok && parity_ok && sync_ok;
    assign last_byte = (byte_idx_q == LAST_IDX);

    // The sync bit is checked on the live byte and parity may be ignored, so these stored bits are not decoded.
    logic unused_bits;
    assign unused_bits = ^{byte0_c[3], parity_q};

    always_comb begin
        // NOTE: every next-state value defaults to its register first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        byte_idx_d = byte_idx_q;
        pkt_d      = pkt_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        x_ovf_d    = x_ovf_q;
        y_ovf_d    = y_ovf_q;
        buttons_d  = buttons_q;
        wheel_d    = wheel_q;
        dir_d      = dir_q;
        speed_d    = speed_q;
        toggle_d   = toggle_q;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (!ps2_data) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                shift_d = {ps2_data, shift_q[7:1]};
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_PARITY;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PARITY: begin
                parity_d = ps2_data;
                state_d  = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
                if (!byte_good) begin
                    byte_idx_d = 2'd0;
                    err_flag_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else if (last_byte) begin
                    dx_d       = dx_c;
                    dy_d       = dy_c;
                    x_ovf_d    = byte0_c[6];
                    y_ovf_d    = byte0_c[7];
                    buttons_d  = byte0_c[2:0];
                    wheel_d    = wheel_c;
                    dir_d      = axis_c[8];
                    speed_d    = speed_c;
                    toggle_d   = ~toggle_q;
                    err_flag_d = 1'b0;
                    byte_idx_d = 2'd0;
                end else begin
                    for (int i = 0; i < NSTORE; i++) begin
                        if (byte_idx_q == 2'(i)) begin
                            pkt_d[i] = shift_q;
                        end
                    end
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge ps2_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            byte_idx_q <= '0;
            // NOTE: the packet buffer is a few flops, not a RAM, so it is cleared with the rest of the state.
            for (int i = 0; i < NSTORE; i++) begin
                pkt_q[i] <= '0;
            end
            dx_q       <= '0;
            dy_q       <= '0;
            x_ovf_q    <= 1'b0;
            y_ovf_q    <= 1'b0;
            buttons_q  <= '0;
            wheel_q    <= '0;
            dir_q      <= 1'b0;
            speed_q    <= '0;
            toggle_q   <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            byte_idx_q <= byte_idx_d;
            pkt_q      <= pkt_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            x_ovf_q    <= x_ovf_d;
            y_ovf_q    <= y_ovf_d;
            buttons_q  <= buttons_d;
            wheel_q    <= wheel_d;
            dir_q      <= dir_d;
            speed_q    <= speed_d;
            toggle_q   <= toggle_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign dx           = dx_q;
    assign dy           = dy_q;
    assign x_ovf        = x_ovf_q;
    assign y_ovf        = y_ovf_q;
    assign buttons      = buttons_q;
    assign wheel        = wheel_q;
    assign paddle_dir   = dir_q;
    assign paddle_speed = speed_q;
    assign pkt_toggle   = toggle_q;
    assign error_flag   = err_flag_q;
    assign err_count    = err_cnt_q;

endmodule
